// File: rtl/coco_clk_pkg.sv
// Shared types and constants for the CoCo clock-enable / reset sequencer.
// The turbo (/32) decode is built only when COCO_CLK_TURBO_EN is defined.
package coco_clk_pkg;

  localparam int unsigned PH_W  = 6;
  localparam int unsigned TPH_W = 5;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } clk_state_e;

  // Normal-mode (/64) edge-advance phases
  localparam logic [PH_W-1:0] NRM_Q_RISE = 6'd15;
  localparam logic [PH_W-1:0] NRM_E_RISE = 6'd31;
  localparam logic [PH_W-1:0] NRM_Q_FALL = 6'd47;
  localparam logic [PH_W-1:0] NRM_E_FALL = 6'd63;

  // Turbo-mode (/32) edge-advance phases, taken on phase[4:0]
  localparam logic [TPH_W-1:0] TRB_Q_RISE = 5'd7;
  localparam logic [TPH_W-1:0] TRB_E_RISE = 5'd15;
  localparam logic [TPH_W-1:0] TRB_Q_FALL = 5'd23;
  localparam logic [TPH_W-1:0] TRB_E_FALL = 5'd31;

  // Divider masks: an enable fires when all masked phase bits are set
  localparam logic [PH_W-1:0] CE14_MASK = 6'h03;
  localparam logic [PH_W-1:0] CE3_MASK  = 6'h0F;
  localparam logic [PH_W-1:0] TRB_MASK  = 6'h1F;

  // All enable / level outputs travel together as one payload
  typedef struct packed {
    logic ce_14m;
    logic ce_3m58;
    logic cpu_e;
    logic cpu_q;
    logic e_rise;
    logic e_fall;
    logic q_rise;
    logic q_fall;
  } ce_bus_t;

  // Video and colour-burst enables are common to both CPU modes
  function automatic ce_bus_t decode_common(logic [PH_W-1:0] ph);
    ce_bus_t c;
    c         = '0;
    c.ce_14m  = ((ph & CE14_MASK) == CE14_MASK);
    c.ce_3m58 = ((ph & CE3_MASK) == CE3_MASK);
    return c;
  endfunction

  // Normal /64 E/Q decode: Q high 16..47, E high 32..63
  function automatic ce_bus_t decode_nrm(logic [PH_W-1:0] ph);
    ce_bus_t c;
    c        = decode_common(ph);
    c.q_rise = (ph == NRM_Q_RISE);
    c.e_rise = (ph == NRM_E_RISE);
    c.q_fall = (ph == NRM_Q_FALL);
    c.e_fall = (ph == NRM_E_FALL);
    c.cpu_q  = ph[5] ^ ph[4];
    c.cpu_e  = ph[5];
    return c;
  endfunction

`ifdef COCO_CLK_TURBO_EN
  // Turbo /32 E/Q decode on phase[4:0]: Q high 8..23, E high 16..31
  function automatic ce_bus_t decode_trb(logic [PH_W-1:0] ph);
    ce_bus_t          c;
    logic [TPH_W-1:0] tp;
    tp       = TPH_W'(ph & TRB_MASK);
    c        = decode_common(ph);
    c.q_rise = (tp == TRB_Q_RISE);
    c.e_rise = (tp == TRB_E_RISE);
    c.q_fall = (tp == TRB_Q_FALL);
    c.e_fall = (tp == TRB_E_FALL);
    c.cpu_q  = tp[4] ^ tp[3];
    c.cpu_e  = tp[4];
    return c;
  endfunction
`endif

endpackage

// File: rtl/coco_clk_en_gen_sync2.sv
// Two-flop synchroniser with synchronous active-low clear.
module coco_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Next-value shift of the two-stage chain
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchroniser flops, cleared synchronously
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/coco_clk_en_gen.sv
// Clock-enable and reset sequencer downstream of the system PLL.
// Holds the core in reset until PLL lock has been stable for LOCK_HOLD
// cycles, then emits single-cycle enables for video, colour burst and
// the 6809 E/Q pair. Define COCO_CLK_TURBO_EN to build the /32 CPU mode.
module coco_clk_en_gen
  import coco_clk_pkg::*;
#(
  parameter int unsigned LOCK_HOLD = 1024
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic pll_locked,
  input  logic turbo,
  output logic sys_rst,
  output logic ce_14m,
  output logic ce_3m58,
  output logic cpu_e,
  output logic cpu_q,
  output logic cpu_e_rise,
  output logic cpu_e_fall,
  output logic cpu_q_rise,
  output logic cpu_q_fall
);

  localparam int unsigned HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

  logic              locked_s;
  clk_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              sys_rst_q, sys_rst_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              turbo_q, turbo_d;
  ce_bus_t           ce_q, ce_d;
  ce_bus_t           dec_c;
  logic              run_c;

  // Bring the asynchronous PLL lock flag into the clk_sys domain
  coco_sync2 u_lock_sync (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Lock sequencing: wait for lock, count a stable hold, then run
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    case (state_q)
      ST_WAIT: begin
        if (locked_s) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (!locked_s) begin
          state_d    = ST_WAIT;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (!locked_s) state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // Phase counter, mode latch and output decode, all from the next state
  always_comb begin
    run_c     = (state_d == ST_RUN);
    sys_rst_d = !run_c;
    phase_d   = (run_c && (state_q == ST_RUN)) ? (phase_q + PH_W'(1)) : '0;
`ifdef COCO_CLK_TURBO_EN
    // Mode only changes right after an E fall (or in reset) so no E/Q
    // period is ever cut short
    turbo_d   = (ce_q.e_fall || sys_rst_q) ? turbo : turbo_q;
    dec_c     = turbo_d ? decode_trb(phase_d) : decode_nrm(phase_d);
`else
    turbo_d   = 1'b0;
    dec_c     = decode_nrm(phase_d);
`endif
    ce_d      = run_c ? dec_c : '0;
  end

  // State, counters and registered outputs with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= ST_WAIT;
      hold_cnt_q <= '0;
      sys_rst_q  <= 1'b1;
      phase_q    <= '0;
      turbo_q    <= 1'b0;
      ce_q       <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      sys_rst_q  <= sys_rst_d;
      phase_q    <= phase_d;
      turbo_q    <= turbo_d;
      ce_q       <= ce_d;
    end
  end

`ifndef COCO_CLK_TURBO_EN
  // Without turbo support the request pin and mode flop have no load
  logic unused_turbo_c;
  assign unused_turbo_c = turbo ^ turbo_q;
`endif

  assign sys_rst    = sys_rst_q;
  assign ce_14m     = ce_q.ce_14m;
  assign ce_3m58    = ce_q.ce_3m58;
  assign cpu_e      = ce_q.cpu_e;
  assign cpu_q      = ce_q.cpu_q;
  assign cpu_e_rise = ce_q.e_rise;
  assign cpu_e_fall = ce_q.e_fall;
  assign cpu_q_rise = ce_q.q_rise;
  assign cpu_q_fall = ce_q.q_fall;

endmodule

// File: tb/tb_coco_clk_en_gen.sv
// Directed self-checking bench for coco_clk_en_gen with LOCK_HOLD = 16.
// Turbo expectations follow COCO_CLK_TURBO_EN.
module tb_coco_clk_en_gen;

  localparam int unsigned LH = 16;
`ifdef COCO_CLK_TURBO_EN
  localparam bit TRB_EN = 1'b1;
`else
  localparam bit TRB_EN = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset_n;
  logic pll_locked;
  logic turbo;
  logic sys_rst, ce_14m, ce_3m58, cpu_e, cpu_q;
  logic cpu_e_rise, cpu_e_fall, cpu_q_rise, cpu_q_fall;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  coco_clk_en_gen #(.LOCK_HOLD(LH)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .turbo      (turbo),
    .sys_rst    (sys_rst),
    .ce_14m     (ce_14m),
    .ce_3m58    (ce_3m58),
    .cpu_e      (cpu_e),
    .cpu_q      (cpu_q),
    .cpu_e_rise (cpu_e_rise),
    .cpu_e_fall (cpu_e_fall),
    .cpu_q_rise (cpu_q_rise),
    .cpu_q_fall (cpu_q_fall)
  );

  wire [7:0] outs = {ce_14m, ce_3m58, cpu_e, cpu_q,
                     cpu_e_rise, cpu_e_fall, cpu_q_rise, cpu_q_fall};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs for a given phase, written from the phase tables
  function automatic logic [7:0] exp_outs(input int ph, input bit trb);
    int   p;
    logic ce14, ce3, e, q, er, ef, qr, qf;
    ce14 = ((ph % 4) == 3);
    ce3  = ((ph % 16) == 15);
    if (trb) begin
      p  = ph % 32;
      qr = (p == 7);  er = (p == 15); qf = (p == 23); ef = (p == 31);
      q  = (p >= 8) && (p <= 23);
      e  = (p >= 16);
    end else begin
      qr = (ph == 15); er = (ph == 31); qf = (ph == 47); ef = (ph == 63);
      q  = (ph >= 16) && (ph <= 47);
      e  = (ph >= 32);
    end
    return {ce14, ce3, e, q, er, ef, qr, qf};
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Advance 'count' cycles checking every output; phase after first tick is ph0
  task automatic run_phases(input string tag, input int ph0, input int count,
                            input bit trb, output int n_ef);
    n_ef = 0;
    for (int i = 0; i < count; i++) begin
      tick();
      check(tag, 32'({sys_rst, outs}), 32'({1'b0, exp_outs((ph0 + i) % 64, trb)}));
      if (cpu_e_fall) n_ef++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nef;
    int qr1, qr2, first_q, first_e, ce14_cnt, ce3_cnt, qh_cnt, eh_cnt;

    reset_n    = 1'b0;
    pll_locked = 1'b0;
    turbo      = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_sys_rst", 32'(sys_rst), 32'd1);
    check("rst_outs", 32'(outs), 32'd0);
    check("rst_phase", 32'(dut.phase_q), 32'd0);
    reset_n = 1'b1;

    // Lock-up: lock rises after edge 10, release at edge 29
    repeat (7) tick();
    check("wait_sys_rst", 32'(sys_rst), 32'd1);
    pll_locked = 1'b1;
    repeat (18) tick();
    check("hold_last_sys_rst", 32'(sys_rst), 32'd1);
    check("hold_last_outs", 32'(outs), 32'd0);
    tick();
    check("release_sys_rst", 32'(sys_rst), 32'd0);
    check("first_run_outs", 32'(outs), 32'd0);

    // Normal E/Q over 128 cycles after release
    qr1 = -1; qr2 = -1; first_q = -1; first_e = -1;
    ce14_cnt = 0; ce3_cnt = 0; qh_cnt = 0; eh_cnt = 0;
    for (int k = 1; k < 128; k++) begin
      tick();
      check("nrm_run", 32'({sys_rst, outs}), 32'({1'b0, exp_outs(k % 64, 1'b0)}));
      if (cpu_q_rise) begin
        if (qr1 < 0) qr1 = k; else qr2 = k;
      end
      if (ce_14m) ce14_cnt++;
      if (ce_3m58) ce3_cnt++;
      if (cpu_q) qh_cnt++;
      if (cpu_e) eh_cnt++;
      if (cpu_q && first_q < 0) first_q = k;
      if (cpu_e && first_e < 0) first_e = k;
    end
    check("q_rise_first", 32'(qr1), 32'd15);
    check("q_rise_second", 32'(qr2), 32'd79);
    check("ce14_count", 32'(ce14_cnt), 32'd32);
    check("ce3_count", 32'(ce3_cnt), 32'd8);
    check("q_duty", 32'(qh_cnt), 32'd64);
    check("e_duty", 32'(eh_cnt), 32'd64);
    check("q_first_high", 32'(first_q), 32'd16);
    check("q_lead_e", 32'(first_e - first_q), 32'd16);

    // Turbo request at phase 40: period stays 64 up to the phase-63 E fall
    run_phases("pre_trb", 0, 41, 1'b0, nef);
    turbo = 1'b1;
    run_phases("trb_wait", 41, 23, 1'b0, nef);
    check("trb_wait_efall", 32'(nef), 32'd1);
    run_phases("trb_run", 0, 64, TRB_EN, nef);
    check("trb_efall_cnt", 32'(nef), TRB_EN ? 32'd2 : 32'd1);

    // Drop turbo right after an E fall, then lose lock at phase 20
    turbo = 1'b0;
    run_phases("trb_off", 0, 21, 1'b0, nef);
    pll_locked = 1'b0;
    run_phases("loss_tail", 21, 2, 1'b0, nef);
    tick();
    check("loss_sys_rst", 32'(sys_rst), 32'd1);
    check("loss_outs", 32'(outs), 32'd0);
    check("loss_phase", 32'(dut.phase_q), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("loss_hold", 32'({sys_rst, outs}), 32'h100);
    end

    // Lock glitch at hold count 10: full restart after re-sync
    pll_locked = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      tick();
      if (i == 13) begin
        check("hold_at_glitch", 32'(dut.hold_cnt_q), 32'd10);
        pll_locked = 1'b0;
      end
      if (i == 16) pll_locked = 1'b1;
      check("glitch_sys_rst", 32'(sys_rst), (i < 35) ? 32'd1 : 32'd0);
    end
    check("relock_first_outs", 32'(outs), 32'd0);
    run_phases("relock_run", 1, 40, 1'b0, nef);

    // One-cycle reset_n mid-RUN, then re-sync and full hold
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_sys_rst", 32'(sys_rst), 32'd1);
    check("mid_rst_outs", 32'(outs), 32'd0);
    check("mid_rst_phase", 32'(dut.phase_q), 32'd0);
    for (int i = 1; i <= 19; i++) begin
      tick();
      check("rerun_sys_rst", 32'(sys_rst), (i < 19) ? 32'd1 : 32'd0);
    end
    check("rerun_first_outs", 32'(outs), 32'd0);
    run_phases("rerun_run", 1, 20, 1'b0, nef);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/coco_clk_en_gen.md
# coco_clk_en_gen

Clock-enable and reset sequencer sitting directly downstream of the system PLL. It consumes the 57.272727 MHz system clock and the PLL's `locked` flag. It holds the core in reset until lock has been stable for a programmable time, then produces single-cycle clock enables for video (14.318 MHz), colour burst (3.579545 MHz) and the 6809 E/Q quadrature pair (0.894886 MHz, or 1.789773 MHz in turbo). All downstream logic runs on `clk_sys` and is qualified by these enables.

## Interface
Parameters:
- `LOCK_HOLD`, default 1024: number of consecutive `clk_sys` cycles with synchronised lock required before reset is released; legal range 2..65536.

Ports:
- `clk_sys`, in, 1: 57.272727 MHz system clock (PLL outclk_0).
- `reset_n`, in, 1: synchronous, active-low reset.
- `pll_locked`, in, 1: PLL lock flag, asynchronous to `clk_sys`.
- `turbo`, in, 1: request double CPU rate; quasi-static.
- `sys_rst`, out, 1: active-high core reset.
- `ce_14m`, out, 1: one-cycle enable at 1/4 of `clk_sys`.
- `ce_3m58`, out, 1: one-cycle enable at 1/16 of `clk_sys`.
- `cpu_e`, out, 1: 6809 E level.
- `cpu_q`, out, 1: 6809 Q level.
- `cpu_e_rise`, `cpu_e_fall`, `cpu_q_rise`, `cpu_q_fall`, out, 1 each: one-cycle edge-advance enables.

## Operation
- Lock synchroniser: two flops on `pll_locked`, producing `locked_s`. Both flops clear on reset.
- The FSM has three states: WAIT, HOLD and RUN.
  - WAIT: `hold_cnt` = 0. If `locked_s` = 1, go to HOLD.
  - HOLD: `hold_cnt` increments each cycle. If `locked_s` = 0, go to WAIT. If `hold_cnt` = LOCK_HOLD-1, go to RUN.
  - RUN: if `locked_s` = 0, go to WAIT.
- `sys_rst` is 1 in WAIT and HOLD and 0 only in RUN. It is registered and derived from the next state.
- Phase counter `phase` is 6 bits. It is 0 outside RUN and increments modulo 64 in RUN.
- Outputs are flops loaded from decodes of the next phase, so each output is aligned with `phase` in the same cycle.
- `ce_14m` = (`phase[1:0]` == 3). `ce_3m58` = (`phase[3:0]` == 15).
- Normal mode (/64):
  - `cpu_q_rise` at phase 15, `cpu_e_rise` at 31, `cpu_q_fall` at 47, `cpu_e_fall` at 63.
  - `cpu_q` is high for phases 16..47. `cpu_e` is high for phases 32..63.
- Turbo mode (/32, uses `phase[4:0]`):
  - Rises at 7 and 15, falls at 23 and 31.
  - `cpu_q` is high for 8..23. `cpu_e` is high for 16..31.
- `turbo_q` (the active mode) loads from `turbo` only in a cycle where `cpu_e_fall` = 1, or while `sys_rst` = 1. This keeps every E/Q period whole.
- All enables and E/Q levels are forced to 0 whenever `sys_rst` = 1.

## Timing
- Reset (`reset_n` = 0) values:
  - Outputs: `sys_rst` = 1, all other outputs 0.
  - Internal: state WAIT, `hold_cnt` = 0, `phase` = 0, `turbo_q` = 0.
- `pll_locked` rising to `sys_rst` falling is 2 sync cycles + 1 WAIT→HOLD cycle + LOCK_HOLD cycles, with `sys_rst` registered.
- First RUN cycle: `phase` = 0, `sys_rst` = 0, no enable asserted.
- `pll_locked` falling to `sys_rst` = 1 is 3 cycles (2 sync + 1 register). All enables are 0 from the same cycle.
- Lock glitch during HOLD restarts the count from 0; there is no partial credit.
- A `reset_n` mid-RUN takes effect on the next edge. There is no enable pulse in that cycle.
- Every `cpu_e_fall` coincides with both `ce_14m` and `ce_3m58`.
- A `turbo` change mid-period takes effect on the cycle after the next `cpu_e_fall`.

## Configuration
- `COCO_CLK_TURBO_EN` defined: turbo mode as above.
- Not defined:
  - The `turbo` port remains but is ignored, and `turbo_q` is constant 0.
  - Only /64 decodes are built.

## Structure
- Package `coco_clk_pkg` holds:
  - FSM state enum (WAIT, HOLD, RUN).
  - Phase constants for normal and turbo edges (Q_RISE, E_RISE, Q_FALL, E_FALL).
  - Divider masks.
- Sub-module `coco_sync2`: two-flop synchroniser with synchronous active-low clear, instantiated for `pll_locked`.

## Test plan
- Lock-up, LOCK_HOLD=16: `pll_locked` 0→1 at cycle 10 → `sys_rst` falls at cycle 29. The first `ce_14m` comes 3 cycles later. `ce_14m` has period 4 and `ce_3m58` has period 16.
- Normal E/Q: run 128 cycles after release → `cpu_q_rise` at phases 15 and 79. `cpu_q`/`cpu_e` have 50% duty and Q leads E by 16 cycles.
- Turbo (`COCO_CLK_TURBO_EN`): assert `turbo` at phase 40 → the period stays 64 until the phase 63 `cpu_e_fall`. The period is then 32, with `cpu_e_rise` at phase 15 of the next period.
- Lock glitch in HOLD: `pll_locked` low for 3 cycles at hold count 10 → `sys_rst` stays 1. The count restarts, and release occurs LOCK_HOLD cycles after re-lock is synchronised.
- Lock loss in RUN at phase 20 → `sys_rst` = 1 exactly 3 cycles later. All enables are 0 thereafter and `phase` = 0.
- `reset_n` = 0 for one cycle mid-RUN → `sys_rst` = 1 the next cycle. After release, lock is re-synchronised and the full hold is repeated.
